codec_init_sequencer: RTL and testbench

Sequences the power-up register configuration of the SSM2603 audio codec over the I2C control path inside `codec_unit`. It sits between reset/start control and the I2C byte-level master. It walks a fixed 12-entry table of 16-bit register words and hands each word to the master through a valid/ready command handshake. It retries words the codec NACKs, inserts the mandated settle delay before activating the codec, and reports completion or failure to `sampler_top` status logic (LEDs).

---
 rtl/codec_init_sequencer_if.sv | 32 +++
 rtl/codec_init_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/codec_init_sequencer_if.sv
// Command channel between the codec init sequencer and the I2C byte-level master.
// The sequencer presents one 16-bit register word per command. The master
// accepts it with a valid/ready handshake, then reports completion with a
// single-cycle done pulse that carries the ACK/NACK result.
interface codec_init_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_dev_addr;
    logic [15:0] cmd_word;
    logic        cmd_done;
    logic        cmd_nack;

    // Sequencer side: issues commands and observes completion.
    modport master (
        output cmd_valid,
        output cmd_dev_addr,
        output cmd_word,
        input  cmd_ready,
        input  cmd_done,
        input  cmd_nack
    );

    // I2C master side: accepts commands and reports completion.
    modport slave (
        input  cmd_valid,
        input  cmd_dev_addr,
        input  cmd_word,
        output cmd_ready,
        output cmd_done,
        output cmd_nack
    );
endinterface

// File: rtl/codec_init_sequencer.sv
// Power-up register sequencer for the SSM2603 codec.
// Walks a fixed 12-entry table of {reg_addr[6:0], reg_data[8:0]} words and
// issues them one at a time to the I2C master. NACKed words are retried up to
// MAX_RETRIES extra times. A settle delay is inserted before the codec is
// activated. Completion or failure is reported on sticky status flags.
// Every output is driven straight from a flop.
module codec_init_sequencer #(
    parameter logic [6:0]  DEV_ADDR      = 7'h1A,
    parameter logic [31:0] SETTLE_CYCLES = 32'd6_250_000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    codec_init_sequencer_if.master        cmd,
    output logic                          busy,
    output logic                          init_done,
    output logic                          init_error,
    output logic [3:0]                    step,
    output logic [7:0]                    nack_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SETTLE,
        ST_DONE,
        ST_ERROR
    } state_e;

    // Index of the last table entry, and of the entry after which the codec
    // needs its settle time before being activated.
    localparam logic [3:0]  LAST_STEP   = 4'd11;
    localparam logic [3:0]  SETTLE_STEP = 4'd9;
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
    localparam logic [31:0] SETTLE_LOAD = SETTLE_CYCLES - 32'd1;

    // Register configuration table, one word per step.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00; // R15 soft reset
            4'd1:    w = 16'h0C10; // R6 power, output stage off
            4'd2:    w = 16'h0017; // R0 left line in
            4'd3:    w = 16'h0217; // R1 right line in
            4'd4:    w = 16'h0479; // R2 left headphone
            4'd5:    w = 16'h0679; // R3 right headphone
            4'd6:    w = 16'h0810; // R4 analogue path, DAC select
            4'd7:    w = 16'h0A00; // R5 digital path
            4'd8:    w = 16'h0E02; // R7 I2S, 16-bit
            4'd9:    w = 16'h1000; // R8 48 kHz normal mode
            4'd10:   w = 16'h1201; // R9 activate
            4'd11:   w = 16'h0C00; // R6 power, output stage on
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    state_e      state_q,      state_d;
    logic        auto_pend_q,  auto_pend_d;
    logic        cmd_valid_q,  cmd_valid_d;
    logic [15:0] cmd_word_q,   cmd_word_d;
    logic        busy_q,       busy_d;
    logic        init_done_q,  init_done_d;
    logic        init_error_q, init_error_d;
    logic [3:0]  step_q,       step_d;
    logic [3:0]  retry_q,      retry_d;
    logic [7:0]  nack_count_q, nack_count_d;
    logic [31:0] settle_q,     settle_d;

    logic [3:0]  step_inc;
    assign step_inc = step_q + 4'd1;

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d      = state_q;
        auto_pend_d  = 1'b0;
        cmd_valid_d  = cmd_valid_q;
        cmd_word_d   = cmd_word_q;
        busy_d       = busy_q;
        init_done_d  = init_done_q;
        init_error_d = init_error_q;
        step_d       = step_q;
        retry_d      = retry_q;
        nack_count_d = nack_count_q;
        settle_d     = settle_q;

        unique case (state_q)
            // Start (or the one-shot auto start after reset) launches a
            // fresh sequence from any resting state and clears the status.
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start || auto_pend_q) begin
                    state_d      = ST_ISSUE;
                    cmd_valid_d  = 1'b1;
                    cmd_word_d   = table_word(4'd0);
                    busy_d       = 1'b1;
                    init_done_d  = 1'b0;
                    init_error_d = 1'b0;
                    step_d       = 4'd0;
                    retry_d      = 4'd0;
                    nack_count_d = 8'd0;
                end
            end

            // Word and valid are held until the master takes the command.
            ST_ISSUE: begin
                if (cmd.cmd_ready) begin
                    state_d     = ST_WAIT;
                    cmd_valid_d = 1'b0;
                end
            end

            ST_WAIT: begin
                if (cmd.cmd_done) begin
                    if (!cmd.cmd_nack) begin
                        retry_d = 4'd0;
                        if (step_q == LAST_STEP) begin
                            state_d     = ST_DONE;
                            busy_d      = 1'b0;
                            init_done_d = 1'b1;
                        end else begin
                            step_d = step_inc;
                            if (step_q == SETTLE_STEP) begin
                                state_d  = ST_SETTLE;
                                settle_d = SETTLE_LOAD;
                            end else begin
                                state_d     = ST_ISSUE;
                                cmd_valid_d = 1'b1;
                                cmd_word_d  = table_word(step_inc);
                            end
                        end
                    end else begin
                        if (nack_count_q != 8'hFF) begin
                            nack_count_d = nack_count_q + 8'd1;
                        end
                        if (retry_q < RETRY_LIMIT) begin
                            state_d     = ST_ISSUE;
                            retry_d     = retry_q + 4'd1;
                            cmd_valid_d = 1'b1;
                            cmd_word_d  = table_word(step_q);
                        end else begin
                            state_d      = ST_ERROR;
                            busy_d       = 1'b0;
                            init_error_d = 1'b1;
                        end
                    end
                end
            end

            // Count down the settle delay, then issue the activate word.
            ST_SETTLE: begin
                if (settle_q == 32'd0) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_word_d  = table_word(step_q);
                end else begin
                    settle_d = settle_q - 32'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            auto_pend_q  <= AUTO_START;
            cmd_valid_q  <= 1'b0;
            cmd_word_q   <= 16'h0000;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            step_q       <= 4'd0;
            retry_q      <= 4'd0;
            nack_count_q <= 8'd0;
            settle_q     <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q      <= state_d;
            auto_pend_q  <= auto_pend_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_word_q   <= cmd_word_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            init_error_q <= init_error_d;
            step_q       <= step_d;
            retry_q      <= retry_d;
            nack_count_q <= nack_count_d;
            settle_q     <= settle_d;
        end
    end

    assign cmd.cmd_valid    = cmd_valid_q;
    assign cmd.cmd_word     = cmd_word_q;
    assign cmd.cmd_dev_addr = DEV_ADDR;
    assign busy             = busy_q;
    assign init_done        = init_done_q;
    assign init_error       = init_error_q;
    assign step             = step_q;
    assign nack_count       = nack_count_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Self-checking bench for codec_init_sequencer.
// DUT A (auto start, short settle) runs against a scripted I2C master model and
// a transaction-level reference: the expected command stream (word, step, gap
// from the triggering event) is built from the register table and NACK script.
// DUT B (no auto start) is exercised with directed literal checks.
module tb_codec_init_sequencer;

    localparam int SETTLE = 10;
    localparam int MAX_R  = 3;
    localparam logic [15:0] TBL [12] = '{
        16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
        16'h0810, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201, 16'h0C00
    };

    typedef struct {
        logic [15:0] word;
        int          gap;
        int          idx;
    } cmd_t;

    logic       clk;
    logic       reset_n;
    logic       start_a, start_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic       err_a, err_b;
    logic [3:0] step_a, step_b;
    logic [7:0] nack_a, nack_b;

    codec_init_sequencer_if a_if ();
    codec_init_sequencer_if b_if ();

    codec_init_sequencer #(
        .DEV_ADDR(7'h1A), .SETTLE_CYCLES(32'(SETTLE)), .MAX_RETRIES(MAX_R), .AUTO_START(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .cmd(a_if.master),
        .busy(busy_a), .init_done(done_a), .init_error(err_a), .step(step_a), .nack_count(nack_a)
    );

    codec_init_sequencer #(
        .DEV_ADDR(7'h1A), .SETTLE_CYCLES(32'(SETTLE)), .MAX_RETRIES(MAX_R), .AUTO_START(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .cmd(b_if.master),
        .busy(busy_b), .init_done(done_b), .init_error(err_b), .step(step_b), .nack_count(nack_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scenario configuration shared by the master model and the reference.
    logic [15:0] cfg_nack_word = 16'h0000;
    int          cfg_nack_times = 0;
    int          nack_left = 0;
    int          bp_left = 0;
    int          acc_total = 0, acc_0217 = 0, acc_0479 = 0, acc_0810 = 0, stall_cnt = 0;
    int          gap_settle = 0;
    logic [15:0] first_word = 16'h0000;

    // I2C master model for DUT A: optional backpressure on 0479, done five
    // cycles after accept, NACK according to the script.
    initial begin
        int cnt;
        bit acc;
        bit pend_nack;
        cnt = 0;
        pend_nack = 1'b0;
        a_if.cmd_ready = 1'b1;
        a_if.cmd_done  = 1'b0;
        a_if.cmd_nack  = 1'b0;
        forever begin
            @(negedge clk);
            acc = reset_n && a_if.cmd_valid && a_if.cmd_ready;
            if (!reset_n) cnt = 0;
            if (reset_n && a_if.cmd_valid && !a_if.cmd_ready && a_if.cmd_word == 16'h0479) stall_cnt++;
            if (acc) begin
                acc_total++;
                if (a_if.cmd_word == 16'h0217) acc_0217++;
                if (a_if.cmd_word == 16'h0479) acc_0479++;
                if (a_if.cmd_word == 16'h0810) acc_0810++;
                cnt = 5;
                pend_nack = 1'b0;
                if (a_if.cmd_word == cfg_nack_word && nack_left > 0) begin
                    pend_nack = 1'b1;
                    if (nack_left != 255) nack_left--;
                end
            end
            @(posedge clk);
            #1;
            a_if.cmd_done = 1'b0;
            a_if.cmd_nack = 1'b0;
            if (!reset_n) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    a_if.cmd_done = 1'b1;
                    a_if.cmd_nack = pend_nack;
                end
            end
            a_if.cmd_ready = !(reset_n && a_if.cmd_valid && a_if.cmd_word == 16'h0479 && bp_left > 0);
            if (!a_if.cmd_ready) bp_left--;
        end
    end

    // Reference model state.
    cmd_t exp_q[$];
    bit   exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    int   exp_nack = 0;
    bit   model_err = 1'b0;
    int   exp_final_step = 11;

    // Expected command stream for one run: every table word in order, each
    // NACKed word repeated, the run ending early once retries are exhausted.
    function automatic void build_model();
        int nk;
        exp_q.delete();
        model_err = 1'b0;
        exp_final_step = 11;
        for (int i = 0; i < 12; i++) begin
            nk = (TBL[i] == cfg_nack_word) ? cfg_nack_times : 0;
            for (int a = 0; a <= MAX_R; a++) begin
                exp_q.push_back(cmd_t'{word: TBL[i], gap: (a == 0 && i == 10) ? SETTLE + 1 : 1, idx: i});
                if (a >= nk) break;
                if (a == MAX_R) begin
                    model_err = 1'b1;
                    exp_final_step = i;
                    return;
                end
            end
        end
    endfunction

    // Compare process for DUT A, sampling on the falling edge.
    bit          prev_valid = 1'b0, prev_ready = 1'b0, prev_rst_n = 1'b0;
    logic [15:0] prev_word = 16'h0000;
    bit          outstanding = 1'b0, final_pending = 1'b0, first_pending = 1'b0;
    int          since_ref = 0;
    always @(negedge clk) begin
        cmd_t e;
        if (!reset_n) begin
            check("rst_valid", 32'(a_if.cmd_valid), 32'd0);
            check("rst_word", 32'(a_if.cmd_word), 32'd0);
            check("rst_busy", 32'(busy_a), 32'd0);
            check("rst_done", 32'(done_a), 32'd0);
            check("rst_error", 32'(err_a), 32'd0);
            check("rst_step", 32'(step_a), 32'd0);
            check("rst_nack", 32'(nack_a), 32'd0);
            exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_nack = 0;
            exp_q.delete();
            outstanding = 1'b0; final_pending = 1'b0;
            prev_valid = 1'b0; prev_ready = 1'b0;
        end else begin
            since_ref++;
            check("busy", 32'(busy_a), 32'(exp_busy));
            check("init_done", 32'(done_a), 32'(exp_done));
            check("init_error", 32'(err_a), 32'(exp_err));
            check("nack_count", 32'(nack_a), 32'(exp_nack));
            check("dev_addr", 32'(a_if.cmd_dev_addr), 32'h1A);
            if (final_pending) begin
                check("final_step", 32'(step_a), 32'(exp_final_step));
                final_pending = 1'b0;
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(a_if.cmd_valid), 32'd1);
                check("hold_word", 32'(a_if.cmd_word), 32'(prev_word));
            end
            if (prev_valid && prev_ready) check("valid_drop", 32'(a_if.cmd_valid), 32'd0);
            if (a_if.cmd_valid && !prev_valid) begin
                check("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("cmd_word", 32'(a_if.cmd_word), 32'(e.word));
                    check("cmd_gap", 32'(since_ref), 32'(e.gap));
                    check("cmd_step", 32'(step_a), 32'(e.idx));
                    if (e.idx == 10) gap_settle = since_ref;
                end
                if (first_pending) begin
                    first_word = a_if.cmd_word;
                    first_pending = 1'b0;
                end
            end
            if (a_if.cmd_valid && a_if.cmd_ready) outstanding = 1'b1;
            if ((start_a && !exp_busy) || !prev_rst_n) begin
                build_model();
                exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0; exp_nack = 0;
                since_ref = 0;
                first_pending = 1'b1;
            end else if (a_if.cmd_done && outstanding) begin
                outstanding = 1'b0;
                since_ref = 0;
                if (a_if.cmd_nack && exp_nack < 255) exp_nack++;
                if (exp_q.size() == 0) begin
                    exp_busy = 1'b0;
                    exp_done = !model_err;
                    exp_err  = model_err;
                    final_pending = 1'b1;
                end
            end
            prev_valid = a_if.cmd_valid;
            prev_ready = a_if.cmd_ready;
            prev_word  = a_if.cmd_word;
        end
        prev_rst_n = reset_n;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (!busy_a) break;
            tick(1);
        end
        check(name, 32'(busy_a), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        b_if.cmd_ready = 1'b1;
        b_if.cmd_done  = 1'b0;
        b_if.cmd_nack  = 1'b0;

        // Scenario 1: clean auto-started run with 7 cycles of backpressure on step 4.
        cfg_nack_word = 16'h0000; cfg_nack_times = 0; nack_left = 0; bp_left = 7;
        tick(3);
        reset_n = 1'b1;

        // DUT B runs alongside: no auto start, spurious done, start while busy.
        tick(4);
        check("b_idle_busy", 32'(busy_b), 32'd0);
        check("b_idle_valid", 32'(b_if.cmd_valid), 32'd0);
        b_if.cmd_done = 1'b1; b_if.cmd_nack = 1'b1;
        tick(1);
        b_if.cmd_done = 1'b0; b_if.cmd_nack = 1'b0;
        tick(1);
        check("b_spur_busy", 32'(busy_b), 32'd0);
        check("b_spur_nack", 32'(nack_b), 32'd0);
        check("b_spur_step", 32'(step_b), 32'd0);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        check("b_start_valid", 32'(b_if.cmd_valid), 32'd1);
        check("b_start_word", 32'(b_if.cmd_word), 32'h1E00);
        check("b_start_busy", 32'(busy_b), 32'd1);
        tick(1);
        check("b_accept_drop", 32'(b_if.cmd_valid), 32'd0);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        tick(2);
        check("b_restart_valid", 32'(b_if.cmd_valid), 32'd0);
        check("b_restart_step", 32'(step_b), 32'd0);
        check("b_restart_busy", 32'(busy_b), 32'd1);
        b_if.cmd_done = 1'b1;
        tick(1);
        b_if.cmd_done = 1'b0;
        check("b_next_valid", 32'(b_if.cmd_valid), 32'd1);
        check("b_next_word", 32'(b_if.cmd_word), 32'h0C10);
        check("b_next_step", 32'(step_b), 32'd1);

        wait_idle_a("s1_timeout");
        check("s1_done", 32'(done_a), 32'd1);
        check("s1_nack", 32'(nack_a), 32'd0);
        check("s1_accepts", 32'(acc_total), 32'd12);
        check("s1_first_word", 32'(first_word), 32'h1E00);
        check("s1_settle_gap", 32'(gap_settle), 32'd11);
        check("s1_bp_accepts", 32'(acc_0479), 32'd1);
        check("s1_bp_stall", 32'(stall_cnt), 32'd7);

        // Scenario 2: step 3 NACKed twice, then recovers.
        tick(2);
        cfg_nack_word = 16'h0217; cfg_nack_times = 2; nack_left = 2; bp_left = 0;
        acc_0217 = 0;
        pulse_start_a();
        wait_idle_a("s2_timeout");
        check("s2_done", 32'(done_a), 32'd1);
        check("s2_nack", 32'(nack_a), 32'd2);
        check("s2_0217_issued", 32'(acc_0217), 32'd3);

        // Scenario 3: step 6 NACKed forever, retries exhausted.
        tick(2);
        cfg_nack_word = 16'h0810; cfg_nack_times = 255; nack_left = 255;
        acc_0810 = 0;
        pulse_start_a();
        wait_idle_a("s3_timeout");
        check("s3_error", 32'(err_a), 32'd1);
        check("s3_done", 32'(done_a), 32'd0);
        check("s3_step", 32'(step_a), 32'd6);
        check("s3_nack", 32'(nack_a), 32'd4);
        check("s3_0810_issued", 32'(acc_0810), 32'd4);

        // Restart out of ERROR, then reset during the settle delay.
        tick(2);
        cfg_nack_word = 16'h0000; cfg_nack_times = 0; nack_left = 0;
        pulse_start_a();
        check("s4_err_clr", 32'(err_a), 32'd0);
        check("s4_nack_clr", 32'(nack_a), 32'd0);
        check("s4_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 1000; i++) begin
            if (step_a == 4'd10 && !a_if.cmd_valid) break;
            tick(1);
        end
        check("s4_reach_settle", 32'(step_a), 32'd10);
        #2;
        reset_n = 1'b0;
        #1;
        check("s4_async_valid", 32'(a_if.cmd_valid), 32'd0);
        check("s4_async_busy", 32'(busy_a), 32'd0);
        check("s4_async_step", 32'(step_a), 32'd0);
        tick(3);
        first_word = 16'h0000;
        reset_n = 1'b1;
        tick(2);
        wait_idle_a("s4_timeout");
        check("s4_first_word", 32'(first_word), 32'h1E00);
        check("s4_done", 32'(done_a), 32'd1);

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
